// File: rtl/axil_gpio_pkg.sv
// rtl/axil_gpio_pkg.sv - shared offsets, response codes, FSM states and byte-strobe helpers for the AXI-Lite GPIO slave
package axil_gpio_pkg;

    localparam logic [2:0] OFF_DATA_OUT = 3'd0;
    localparam logic [2:0] OFF_DATA_IN  = 3'd1;
    localparam logic [2:0] OFF_DIR      = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = {8{strb[b]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_gpio_slave_if.sv
// rtl/axil_gpio_slave_if.sv - AXI4-Lite bus bundle between the LSU initiator and the GPIO slave
interface axil_gpio_slave_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] s_axi_awaddr_i;
    logic              s_axi_awvalid_i;
    logic              s_axi_awready_o;
    logic [31:0]       s_axi_wdata_i;
    logic [3:0]        s_axi_wstrb_i;
    logic              s_axi_wvalid_i;
    logic              s_axi_wready_o;
    logic [1:0]        s_axi_bresp_o;
    logic              s_axi_bvalid_o;
    logic              s_axi_bready_i;
    logic [ADDR_W-1:0] s_axi_araddr_i;
    logic              s_axi_arvalid_i;
    logic              s_axi_arready_o;
    logic [31:0]       s_axi_rdata_o;
    logic [1:0]        s_axi_rresp_o;
    logic              s_axi_rvalid_o;
    logic              s_axi_rready_i;

    modport slave (
        input  s_axi_awaddr_i, s_axi_awvalid_i, s_axi_wdata_i, s_axi_wstrb_i, s_axi_wvalid_i,
               s_axi_bready_i, s_axi_araddr_i, s_axi_arvalid_i, s_axi_rready_i,
        output s_axi_awready_o, s_axi_wready_o, s_axi_bresp_o, s_axi_bvalid_o,
               s_axi_arready_o, s_axi_rdata_o, s_axi_rresp_o, s_axi_rvalid_o
    );

    modport master (
        output s_axi_awaddr_i, s_axi_awvalid_i, s_axi_wdata_i, s_axi_wstrb_i, s_axi_wvalid_i,
               s_axi_bready_i, s_axi_araddr_i, s_axi_arvalid_i, s_axi_rready_i,
        input  s_axi_awready_o, s_axi_wready_o, s_axi_bresp_o, s_axi_bvalid_o,
               s_axi_arready_o, s_axi_rdata_o, s_axi_rresp_o, s_axi_rvalid_o
    );
endinterface

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - W-wide 2-flop input synchronizer with a previous-sample stage for edge detection
module gpio_sync #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_prev
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_prev = r_prev;
endmodule

// File: rtl/axil_gpio_slave.sv
// rtl/axil_gpio_slave.sv - AXI4-Lite GPIO register bank; AXIL_GPIO_IRQ_EN adds rising-edge interrupts
module axil_gpio_slave
    import axil_gpio_pkg::*;
#(
    parameter int          GPIO_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axil_gpio_slave_if.slave  s_axi,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o
`ifdef AXIL_GPIO_IRQ_EN
   ,output logic              irq_o
`endif
);
    wr_state_t         r_wstate, w_wstate_next;
    rd_state_t         r_rstate, w_rstate_next;
    logic              r_awready, r_wready;
    logic [2:0]        r_awoff;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_bresp;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic [GPIO_W-1:0] r_data_out, r_dir;
    logic [GPIO_W-1:0] w_data_out_next, w_dir_next;
    logic [GPIO_W-1:0] w_sync, w_prev;
    logic              w_aw_have, w_w_have, w_wr_commit, w_wr_ok;
    logic [2:0]        w_woff, w_roff;
    logic [31:0]       w_wdata, w_wmerged, w_rd_val;
    logic [3:0]        w_wstrb;
    logic [1:0]        w_rd_resp;
`ifdef AXIL_GPIO_IRQ_EN
    logic [GPIO_W-1:0] r_irq_en, r_irq_stat;
    logic [GPIO_W-1:0] w_irq_en_next, w_irq_stat_next, w_irq_clr;
    logic              r_irq;
`endif

    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        logic [31:0] res;
        res           = '0;
        res[GPIO_W-1:0] = v;
        return res;
    endfunction

    gpio_sync #(.W(GPIO_W)) u_sync (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_async (gpio_i),
        .o_sync  (w_sync),
        .o_prev  (w_prev)
    );

    // An address/data beat counts as present if already held or arriving this cycle,
    // so a commit can happen on the same edge as the last handshake.
    always_comb begin
        w_aw_have   = !r_awready || s_axi.s_axi_awvalid_i;
        w_w_have    = !r_wready || s_axi.s_axi_wvalid_i;
        w_wr_commit = (r_wstate == W_IDLE) && w_aw_have && w_w_have;
        w_woff      = r_awready ? s_axi.s_axi_awaddr_i[4:2] : r_awoff;
        w_wdata     = r_wready ? s_axi.s_axi_wdata_i : r_wdata;
        w_wstrb     = r_wready ? s_axi.s_axi_wstrb_i : r_wstrb;
        w_wstate_next = r_wstate;
        if (r_wstate == W_IDLE) begin
            if (w_wr_commit) w_wstate_next = W_RESP;
        end else if (s_axi.s_axi_bready_i) begin
            w_wstate_next = W_IDLE;
        end
        w_rstate_next = r_rstate;
        if (r_rstate == R_IDLE) begin
            if (s_axi.s_axi_arvalid_i) w_rstate_next = R_DATA;
        end else if (s_axi.s_axi_rready_i) begin
            w_rstate_next = R_IDLE;
        end
    end

    always_comb begin
        w_data_out_next = r_data_out;
        w_dir_next      = r_dir;
        w_wr_ok         = 1'b0;
        w_wmerged       = '0;
`ifdef AXIL_GPIO_IRQ_EN
        w_irq_en_next   = r_irq_en;
        w_irq_clr       = '0;
`endif
        case (w_woff)
            OFF_DATA_OUT: begin
                w_wr_ok   = 1'b1;
                w_wmerged = apply_wstrb(zext(r_data_out), w_wdata, w_wstrb);
                if (w_wr_commit) w_data_out_next = w_wmerged[GPIO_W-1:0];
            end
            OFF_DATA_IN: w_wr_ok = 1'b1;
            OFF_DIR: begin
                w_wr_ok   = 1'b1;
                w_wmerged = apply_wstrb(zext(r_dir), w_wdata, w_wstrb);
                if (w_wr_commit) w_dir_next = w_wmerged[GPIO_W-1:0];
            end
`ifdef AXIL_GPIO_IRQ_EN
            OFF_IRQ_EN: begin
                w_wr_ok   = 1'b1;
                w_wmerged = apply_wstrb(zext(r_irq_en), w_wdata, w_wstrb);
                if (w_wr_commit) w_irq_en_next = w_wmerged[GPIO_W-1:0];
            end
            OFF_IRQ_STAT: begin
                w_wr_ok   = 1'b1;
                w_wmerged = w_wdata & strb_mask(w_wstrb);
                if (w_wr_commit) w_irq_clr = w_wmerged[GPIO_W-1:0];
            end
`endif
            default: w_wr_ok = 1'b0;
        endcase
`ifdef AXIL_GPIO_IRQ_EN
        // Set is ORed in after the clear so a coincident edge wins.
        w_irq_stat_next = (r_irq_stat & ~w_irq_clr) | (w_sync & ~w_prev);
`endif
    end

    always_comb begin
        w_roff    = s_axi.s_axi_araddr_i[4:2];
        w_rd_val  = '0;
        w_rd_resp = RESP_OKAY;
        case (w_roff)
            OFF_DATA_OUT: w_rd_val = zext(r_data_out);
            OFF_DATA_IN:  w_rd_val = zext(w_sync);
            OFF_DIR:      w_rd_val = zext(r_dir);
`ifdef AXIL_GPIO_IRQ_EN
            OFF_IRQ_EN:   w_rd_val = zext(r_irq_en);
            OFF_IRQ_STAT: w_rd_val = zext(r_irq_stat);
`endif
            default:      w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_awoff    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_data_out <= OUT_RST[GPIO_W-1:0];
            r_dir      <= '0;
        end else begin
            if (r_awready && s_axi.s_axi_awvalid_i) begin
                r_awoff   <= s_axi.s_axi_awaddr_i[4:2];
                r_awready <= 1'b0;
            end
            if (r_wready && s_axi.s_axi_wvalid_i) begin
                r_wdata  <= s_axi.s_axi_wdata_i;
                r_wstrb  <= s_axi.s_axi_wstrb_i;
                r_wready <= 1'b0;
            end
            if (w_wr_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (r_wstate == W_RESP && s_axi.s_axi_bready_i) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
            if (r_rstate == R_IDLE && s_axi.s_axi_arvalid_i) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_resp;
            end
            r_data_out <= w_data_out_next;
            r_dir      <= w_dir_next;
        end
    end

`ifdef AXIL_GPIO_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_en   <= w_irq_en_next;
            r_irq_stat <= w_irq_stat_next;
            r_irq      <= |(w_irq_stat_next & w_irq_en_next);
        end
    end
    assign irq_o = r_irq;
    logic w_unused_bits;
    assign w_unused_bits = ^{s_axi.s_axi_awaddr_i[ADDR_W-1:5], s_axi.s_axi_awaddr_i[1:0],
                             s_axi.s_axi_araddr_i[ADDR_W-1:5], s_axi.s_axi_araddr_i[1:0]};
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{s_axi.s_axi_awaddr_i[ADDR_W-1:5], s_axi.s_axi_awaddr_i[1:0],
                             s_axi.s_axi_araddr_i[ADDR_W-1:5], s_axi.s_axi_araddr_i[1:0], w_prev};
`endif

    assign s_axi.s_axi_awready_o = r_awready;
    assign s_axi.s_axi_wready_o  = r_wready;
    assign s_axi.s_axi_bvalid_o  = (r_wstate == W_RESP);
    assign s_axi.s_axi_bresp_o   = r_bresp;
    assign s_axi.s_axi_arready_o = (r_rstate == R_IDLE);
    assign s_axi.s_axi_rvalid_o  = (r_rstate == R_DATA);
    assign s_axi.s_axi_rdata_o   = r_rdata;
    assign s_axi.s_axi_rresp_o   = r_rresp;
    assign gpio_o                = r_data_out;
    assign gpio_oe_o             = r_dir;
endmodule

// File: tb/tb_axil_gpio_slave.sv
// tb/tb_axil_gpio_slave.sv - directed self-checking bench for axil_gpio_slave
module tb_axil_gpio_slave;
    import axil_gpio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
`ifdef AXIL_GPIO_IRQ_EN
    logic        irq;
`endif
    int          n_checks = 0;
    int          n_fail   = 0;
    int          t;
    logic [31:0] rd;
    logic [1:0]  rsp;

    always #5 clk = ~clk;

    axil_gpio_slave_if #(.ADDR_W(32)) bus ();

    axil_gpio_slave #(.GPIO_W(32), .ADDR_W(32), .OUT_RST(32'h0)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_axi     (bus.slave),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe)
`ifdef AXIL_GPIO_IRQ_EN
       ,.irq_o     (irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int k;
        @(negedge clk);
        bus.s_axi_awaddr_i  = addr;
        bus.s_axi_awvalid_i = 1'b1;
        bus.s_axi_wdata_i   = data;
        bus.s_axi_wstrb_i   = strb;
        bus.s_axi_wvalid_i  = 1'b1;
        bus.s_axi_bready_i  = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid_i = 1'b0;
        bus.s_axi_wvalid_i  = 1'b0;
        k = 0;
        while (!bus.s_axi_bvalid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bvalid_seen", bus.s_axi_bvalid_o, 1);
        resp = bus.s_axi_bresp_o;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int k;
        @(negedge clk);
        bus.s_axi_araddr_i  = addr;
        bus.s_axi_arvalid_i = 1'b1;
        bus.s_axi_rready_i  = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid_i = 1'b0;
        k = 0;
        while (!bus.s_axi_rvalid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rvalid_seen", bus.s_axi_rvalid_o, 1);
        data = bus.s_axi_rdata_o;
        resp = bus.s_axi_rresp_o;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_axi_awaddr_i = '0; bus.s_axi_awvalid_i = 1'b0;
        bus.s_axi_wdata_i  = '0; bus.s_axi_wstrb_i   = '0; bus.s_axi_wvalid_i = 1'b0;
        bus.s_axi_bready_i = 1'b1;
        bus.s_axi_araddr_i = '0; bus.s_axi_arvalid_i = 1'b0; bus.s_axi_rready_i = 1'b1;
        gpio_in = '0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", bus.s_axi_awready_o, 1);
        chk("rst_wready",  bus.s_axi_wready_o, 1);
        chk("rst_arready", bus.s_axi_arready_o, 1);
        chk("rst_bvalid",  bus.s_axi_bvalid_o, 0);
        chk("rst_rvalid",  bus.s_axi_rvalid_o, 0);
        chk("rst_gpio_o",  gpio_out, 32'h0);
        chk("rst_gpio_oe", gpio_oe, 32'h0);
        rst = 1'b0;
        axi_read(32'h08, rd, rsp);
        chk("rst_dir_rdata", rd, 32'h0);
        chk("rst_dir_rresp", rsp, RESP_OKAY);

        // AW at cycle 0, W at cycle 3
        @(negedge clk);
        bus.s_axi_awaddr_i = 32'h00; bus.s_axi_awvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid_i = 1'b0;
        chk("aw_held_awready", bus.s_axi_awready_o, 0);
        @(negedge clk);
        @(negedge clk);
        chk("aw_only_bvalid", bus.s_axi_bvalid_o, 0);
        bus.s_axi_wdata_i = 32'hA5A5_0F0F; bus.s_axi_wstrb_i = 4'hF; bus.s_axi_wvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_wvalid_i = 1'b0;
        chk("split_bvalid", bus.s_axi_bvalid_o, 1);
        chk("split_bresp",  bus.s_axi_bresp_o, RESP_OKAY);
        chk("split_gpio_o", gpio_out, 32'hA5A5_0F0F);
        @(negedge clk);
        chk("split_bdone",   bus.s_axi_bvalid_o, 0);
        chk("split_awready", bus.s_axi_awready_o, 1);
        axi_read(32'h00, rd, rsp);
        chk("split_readback", rd, 32'hA5A5_0F0F);

        // byte strobes
        axi_write(32'h00, 32'h0, 4'hF, rsp);
        axi_write(32'h00, 32'h1234_5678, 4'h2, rsp);
        axi_read(32'h00, rd, rsp);
        chk("strb_byte1", rd, 32'h0000_5600);
        chk("strb_gpio_o", gpio_out, 32'h0000_5600);

        // bready held low for 5 cycles
        @(negedge clk);
        bus.s_axi_bready_i = 1'b0;
        bus.s_axi_awaddr_i = 32'h08; bus.s_axi_awvalid_i = 1'b1;
        bus.s_axi_wdata_i  = 32'h0000_00F0; bus.s_axi_wstrb_i = 4'hF; bus.s_axi_wvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid_i = 1'b0; bus.s_axi_wvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bhold_bvalid",  bus.s_axi_bvalid_o, 1);
            chk("bhold_bresp",   bus.s_axi_bresp_o, RESP_OKAY);
            chk("bhold_awready", bus.s_axi_awready_o, 0);
            @(negedge clk);
        end
        bus.s_axi_bready_i = 1'b1;
        @(negedge clk);
        chk("bhold_release_bvalid", bus.s_axi_bvalid_o, 0);
        chk("bhold_release_awready", bus.s_axi_awready_o, 1);
        chk("dir_gpio_oe", gpio_oe, 32'h0000_00F0);

        // DATA_IN through the synchronizer, rready held low
        gpio_in = 32'h0000_00FF;
        repeat (3) @(negedge clk);
        bus.s_axi_rready_i = 1'b0;
        bus.s_axi_araddr_i = 32'h04; bus.s_axi_arvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid_i = 1'b0;
        gpio_in = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("rhold_rvalid",  bus.s_axi_rvalid_o, 1);
            chk("rhold_rdata",   bus.s_axi_rdata_o, 32'h0000_00FF);
            chk("rhold_arready", bus.s_axi_arready_o, 0);
            @(negedge clk);
        end
        bus.s_axi_rready_i = 1'b1;
        @(negedge clk);
        chk("rhold_release_rvalid", bus.s_axi_rvalid_o, 0);
        chk("rhold_release_arready", bus.s_axi_arready_o, 1);

        // unmapped offsets and RO write
        axi_read(32'h1C, rd, rsp);
        chk("unmapped_rd_data", rd, 32'h0);
        chk("unmapped_rd_resp", rsp, RESP_SLVERR);
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, rsp);
        chk("unmapped_wr_resp", rsp, RESP_SLVERR);
        axi_read(32'h00, rd, rsp);
        chk("unmapped_wr_data_out", rd, 32'h0000_5600);
        axi_read(32'h08, rd, rsp);
        chk("unmapped_wr_dir", rd, 32'h0000_00F0);
        axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, rsp);
        chk("ro_wr_resp", rsp, RESP_OKAY);
        chk("ro_wr_gpio_o", gpio_out, 32'h0000_5600);

        // simultaneous read and write to DATA_OUT
        @(negedge clk);
        bus.s_axi_awaddr_i = 32'h00; bus.s_axi_awvalid_i = 1'b1;
        bus.s_axi_wdata_i  = 32'hDEAD_BEEF; bus.s_axi_wstrb_i = 4'hF; bus.s_axi_wvalid_i = 1'b1;
        bus.s_axi_araddr_i = 32'h00; bus.s_axi_arvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid_i = 1'b0; bus.s_axi_wvalid_i = 1'b0; bus.s_axi_arvalid_i = 1'b0;
        chk("rw_same_rvalid", bus.s_axi_rvalid_o, 1);
        chk("rw_same_rdata",  bus.s_axi_rdata_o, 32'h0000_5600);
        chk("rw_same_bvalid", bus.s_axi_bvalid_o, 1);
        chk("rw_same_gpio_o", gpio_out, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rw_same_done", {bus.s_axi_rvalid_o, bus.s_axi_bvalid_o}, 2'b00);

`ifdef AXIL_GPIO_IRQ_EN
        axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, rsp);
        axi_write(32'h0C, 32'h1, 4'hF, rsp);
        chk("irq_idle", irq, 0);
        gpio_in = 32'h1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!irq && t < 4);
        chk("irq_rise", irq, 1);
        axi_write(32'h10, 32'h1, 4'hF, rsp);
        chk("irq_cleared", irq, 0);
        axi_read(32'h10, rd, rsp);
        chk("irq_stat_cleared", rd, 32'h0);
        gpio_in = 32'h0;
        repeat (4) @(negedge clk);
        gpio_in = 32'h1;
        @(negedge clk);
        @(negedge clk);
        bus.s_axi_awaddr_i = 32'h10; bus.s_axi_awvalid_i = 1'b1;
        bus.s_axi_wdata_i  = 32'h1; bus.s_axi_wstrb_i = 4'hF; bus.s_axi_wvalid_i = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid_i = 1'b0; bus.s_axi_wvalid_i = 1'b0;
        chk("irq_coinc_bvalid", bus.s_axi_bvalid_o, 1);
        @(negedge clk);
        axi_read(32'h10, rd, rsp);
        chk("irq_coinc_stat", rd, 32'h1);
        chk("irq_coinc_irq", irq, 1);
`else
        axi_write(32'h0C, 32'h1, 4'hF, rsp);
        chk("noirq_en_wr_resp", rsp, RESP_SLVERR);
        axi_read(32'h10, rd, rsp);
        chk("noirq_stat_rd_resp", rsp, RESP_SLVERR);
        chk("noirq_stat_rd_data", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
